// File: rtl/rv32_pkg.sv
// Shared RV32 fetch types: NOP encoding, fetch FSM states and the buffered fetch entry.
package rv32_pkg;

   localparam int          XLEN   = 32;
   localparam logic [31:0] RV_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      FLUSH
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return a & ~32'h3;
   endfunction

endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO of fetched {pc, inst} entries with single-cycle flush.
module fetch_buf
   import rv32_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  fetch_entry_t           push_data,
   input  logic                   pop,
   output fetch_entry_t           head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(do_push);
         rd_ptr <= rd_ptr + AW'(do_pop);
         count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage is pure data; pointers alone define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_ctl.sv
// Instruction-fetch front end: PC, imem request/response tracking, wrong-path drop, decode output.
// Optional FETCH_MISALIGN_CHK_EN: flag misaligned redirect targets (sticky until rst).
module fetch_ctl
   import rv32_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2,
   parameter int          MAX_OUTST = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        pcSel,
   input  logic [31:0] pc_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   output logic        fetch_misalign
);

   localparam int CW  = $clog2(MAX_OUTST + 1);
   localparam int BCW = $clog2(BUF_DEPTH) + 1;

   fetch_state_e state, state_nxt;
   logic [31:0]  pc;
   logic [31:0]  rsp_pc;
   logic [CW-1:0] outst, outst_nxt;
   logic [CW-1:0] drop, drop_nxt;
   logic         issue, push, take, buf_push, buf_pop;
   fetch_entry_t buf_head, rsp_entry;
   logic [BCW-1:0] buf_count;
   logic         buf_full, buf_empty;

   assign imem_addr = pc;
   assign rsp_entry = '{pc: rsp_pc, inst: imem_rdata};

   always_comb begin
      state_nxt = state;
      drop_nxt  = drop;
      imem_req  = (state == RUN) && !pcSel && (int'(outst) < MAX_OUTST)
                  && (int'(buf_count) + int'(outst) < BUF_DEPTH);
      issue     = imem_req && imem_gnt;
      push      = imem_rvalid && !pcSel && (drop == '0);
      outst_nxt = outst + CW'(issue) - CW'(imem_rvalid);
      if (pcSel)
         drop_nxt = outst - CW'(imem_rvalid);
      else if (imem_rvalid && drop != '0)
         drop_nxt = drop - CW'(1);
      // A redirect kills the presented instruction, so nothing is taken that cycle.
      take      = !pcSel && (!stall || !inst_valid);
      buf_pop   = take && !buf_empty;
      buf_push  = push && !(take && buf_empty);
      case (state)
         BOOT:    state_nxt = RUN;
         RUN:     if (pcSel && outst != '0) state_nxt = FLUSH;
         FLUSH:   if (drop_nxt == '0) state_nxt = RUN;
         default: state_nxt = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= BOOT;
         pc         <= RESET_PC;
         rsp_pc     <= RESET_PC;
         outst      <= '0;
         drop       <= '0;
         inst       <= RV_NOP;
         inst_pc    <= '0;
         inst_valid <= 1'b0;
      end else begin
         state <= state_nxt;
         outst <= outst_nxt;
         drop  <= drop_nxt;
         // rsp_pc tracks the PC of the next surviving response; responses are in order.
         if (pcSel) begin
            pc     <= word_align(pc_target);
            rsp_pc <= word_align(pc_target);
         end else begin
            if (issue) pc     <= pc + 32'd4;
            if (push)  rsp_pc <= rsp_pc + 32'd4;
         end
         if (pcSel) begin
            inst       <= RV_NOP;
            inst_valid <= 1'b0;
         end else if (take) begin
            if (!buf_empty) begin
               inst       <= buf_head.inst;
               inst_pc    <= buf_head.pc;
               inst_valid <= 1'b1;
            end else if (push) begin
               inst       <= rsp_entry.inst;
               inst_pc    <= rsp_entry.pc;
               inst_valid <= 1'b1;
            end else begin
               inst       <= RV_NOP;
               inst_valid <= 1'b0;
            end
         end
      end
   end

   fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (pcSel),
      .push      (buf_push),
      .push_data (rsp_entry),
      .pop       (buf_pop),
      .head      (buf_head),
      .count     (buf_count),
      .full      (buf_full),
      .empty     (buf_empty)
   );

   // The request rule keeps buf_count + outst <= BUF_DEPTH, so a full buffer never sees a response.
   assert property (@(posedge clk) disable iff (rst) !(imem_rvalid && buf_full));

`ifdef FETCH_MISALIGN_CHK_EN
   logic misalign;

   always_ff @(posedge clk) begin
      if (rst)
         misalign <= 1'b0;
      else if (pcSel && pc_target[1:0] != 2'b00)
         misalign <= 1'b1;
   end

   assign fetch_misalign = misalign;
`else
   assign fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctl.sv
// Scoreboard bench for fetch_ctl: imem model with random grant/latency, program-order reference.
module tb_fetch_ctl;

   localparam logic [31:0] NOP       = 32'h0000_0013;
   localparam int          BUF_DEPTH = 2;
`ifdef FETCH_MISALIGN_CHK_EN
   localparam logic        MIS_EXP   = 1'b1;
`else
   localparam logic        MIS_EXP   = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, stall, pcSel, imem_gnt, imem_rvalid;
   logic [31:0] pc_target, imem_rdata;
   logic        imem_req, inst_valid, fetch_misalign;
   logic [31:0] imem_addr, inst, inst_pc;

   always #5 clk = ~clk;

   fetch_ctl #(.RESET_PC(32'h0), .BUF_DEPTH(BUF_DEPTH), .MAX_OUTST(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .pcSel          (pcSel),
      .pc_target      (pc_target),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_valid     (inst_valid),
      .fetch_misalign (fetch_misalign)
   );

   typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;
   typedef struct { logic [31:0] addr; int ready; } fl_t;

   exp_t        exp_q[$];
   fl_t         fl_q[$];
   exp_t        mon_e;
   fl_t         fl_tmp;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] fetch_pc = 32'h0;
   logic        flag_m = 1'b0;
   int          mem_lat = 1;
   bit          lat_rand = 1'b0;
   int          first_gnt = -1;
   int          first_valid = -1;
   logic        pv = 1'b0, ps = 1'b0, pp = 1'b0, pr = 1'b0;
   logic [31:0] pi = '0, ppc = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // One clock: instruction memory returns the oldest due response in order.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (fl_q.size() > 0 && fl_q[0].ready <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(fl_q[0].addr);
         fl_tmp      = fl_q.pop_front();
      end
   endtask

   // Monitor: program-order reference; accepted instructions are compared against the queue.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            fl_q.delete();
            fetch_pc = 32'h0;
            flag_m   = 1'b0;
            pr = 1'b1; pv = 1'b0; ps = 1'b0; pp = 1'b0;
         end else begin
            if (pr) begin
               chk(inst === NOP,          "reset_inst",  inst, NOP);
               chk(inst_pc === 32'h0,     "reset_pc",    inst_pc, 32'h0);
               chk(inst_valid === 1'b0,   "reset_valid", 32'(inst_valid), 32'h0);
               chk(imem_req === 1'b0,     "reset_req",   32'(imem_req), 32'h0);
               chk(fetch_misalign === 1'b0, "reset_misalign", 32'(fetch_misalign), 32'h0);
            end
            if (pv && ps && !pp) begin
               chk(inst === pi,         "hold_inst",  inst, pi);
               chk(inst_pc === ppc,     "hold_pc",    inst_pc, ppc);
               chk(inst_valid === 1'b1, "hold_valid", 32'(inst_valid), 32'h1);
            end
            if (pp) chk(inst_valid === 1'b0, "redirect_invalid", 32'(inst_valid), 32'h0);
            if (inst_valid !== 1'b1) chk(inst === NOP, "nop_when_invalid", inst, NOP);
            chk(fetch_misalign === flag_m, "misalign_flag", 32'(fetch_misalign), 32'(flag_m));
            if (pcSel) chk(imem_req === 1'b0, "no_req_on_redirect", 32'(imem_req), 32'h0);
            if (imem_req === 1'b1)
               chk(exp_q.size() < BUF_DEPTH + int'(inst_valid), "req_capacity",
                   32'(exp_q.size()), 32'(BUF_DEPTH + int'(inst_valid) - 1));
            if (inst_valid === 1'b1 && first_valid < 0) first_valid = cyc;
            if (inst_valid === 1'b1 && !stall && !pcSel) begin
               if (exp_q.size() == 0) begin
                  chk(1'b0, "unexpected_inst", inst_pc, 32'h0);
               end else begin
                  mon_e = exp_q.pop_front();
                  chk(inst_pc === mon_e.pc,   "inst_pc",   inst_pc, mon_e.pc);
                  chk(inst === mon_e.word,    "inst_word", inst, mon_e.word);
               end
            end
            if (imem_req === 1'b1 && imem_gnt) begin
               chk(imem_addr === fetch_pc, "imem_addr", imem_addr, fetch_pc);
               exp_q.push_back('{pc: fetch_pc, word: mem_word(fetch_pc)});
               fl_q.push_back('{addr: imem_addr,
                                ready: cyc + (lat_rand ? int'($urandom_range(3, 1)) : mem_lat)});
               if (first_gnt < 0) first_gnt = cyc;
               fetch_pc = fetch_pc + 32'd4;
            end
            if (pcSel) begin
               exp_q.delete();
               fetch_pc = pc_target & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_CHK_EN
               if (pc_target[1:0] != 2'b00) flag_m = 1'b1;
`endif
            end
            pr = 1'b0; pv = inst_valid; ps = stall; pp = pcSel; pi = inst; ppc = inst_pc;
         end
      end
   end

   initial begin
      bit found;
      int n;
      rst = 1'b1; stall = 1'b0; pcSel = 1'b0; pc_target = '0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      repeat (3) step();
      step();
      rst = 1'b0; imem_gnt = 1'b1; mem_lat = 1;

      for (int i = 0; i < 20 && first_valid < 0; i++) step();
      chk(first_valid >= 0 && first_valid - first_gnt == 2, "first_latency",
          32'(first_valid - first_gnt), 32'd2);

      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (inst_valid === 1'b1 && inst_pc === 32'h8) begin found = 1'b1; break; end
         step();
      end
      chk(found, "reach_pc8", inst_pc, 32'h8);
      stall = 1'b1;
      step();
      step();
      #1;
      chk(imem_req === 1'b0, "stall_no_req", 32'(imem_req), 32'h0);
      chk(inst_pc === 32'h8, "stall_pc8", inst_pc, 32'h8);
      step();
      stall = 1'b0;

      n = 0;
      repeat (8) begin
         step();
         if (inst_valid === 1'b1) n++;
      end
      chk(n == 8, "throughput", 32'(n), 32'd8);

      mem_lat = 3;
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (fl_q.size() == 2 && !imem_rvalid) begin found = 1'b1; break; end
      end
      chk(found, "two_in_flight", 32'(fl_q.size()), 32'd2);
      pcSel = 1'b1; pc_target = 32'h100;
      step();
      pcSel = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (inst_valid === 1'b1) begin found = 1'b1; break; end
      end
      chk(found && inst_pc === 32'h100, "redirect_pc", inst_pc, 32'h100);

      mem_lat = 1;
      stall = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (imem_rvalid) begin found = 1'b1; break; end
      end
      chk(found, "rvalid_seen", 32'(found), 32'h1);
      pcSel = 1'b1; pc_target = 32'h200;
      step();
      pcSel = 1'b0; stall = 1'b0;
      chk(inst_valid === 1'b0, "redirect_rvalid_stall", 32'(inst_valid), 32'h0);

      pcSel = 1'b1; pc_target = 32'hFFFF_FFF0;
      step();
      pcSel = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (inst_valid === 1'b1 && inst_pc === 32'hFFFF_FFFC) begin found = 1'b1; break; end
      end
      step();
      chk(found && inst_valid === 1'b1 && inst_pc === 32'h0, "pc_wrap", inst_pc, 32'h0);

      pcSel = 1'b1; pc_target = 32'h102;
      step();
      pcSel = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (imem_req === 1'b1) begin found = 1'b1; break; end
         step();
      end
      chk(found && imem_addr === 32'h100, "misalign_addr", imem_addr, 32'h100);
      chk(fetch_misalign === MIS_EXP, "misalign_out", 32'(fetch_misalign), 32'(MIS_EXP));

      lat_rand = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         step();
         rst       = (i >= 1500 && i < 1502);
         imem_gnt  = ($urandom_range(9, 0) < 7);
         stall     = ($urandom_range(3, 0) == 0);
         pcSel     = !rst && ($urandom_range(24, 0) == 0);
         pc_target = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                 : ($urandom & 32'h0003_FFFF);
      end
      rst = 1'b0; pcSel = 1'b0; stall = 1'b0;
      repeat (10) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
